// File: rtl/mode7_pkg.sv
// Shared definitions for the Mode 7 parameter path: slot indices, parameter
// width, reset defaults, the 360-degree wrap constant and the sequencer
// state encoding. Imported by the sequencer, its handshake interface and the
// angle step adder (which the input front end also reuses).
package mode7_pkg;

  localparam int PARAM_W    = 24;  // 16.8 fixed point
  localparam int NUM_PARAMS = 9;
  localparam int SEL_W      = 4;

  localparam logic [SEL_W-1:0] SEL_OFFSETX  = 4'd0;
  localparam logic [SEL_W-1:0] SEL_OFFSETY  = 4'd1;
  localparam logic [SEL_W-1:0] SEL_ORIGINX  = 4'd2;
  localparam logic [SEL_W-1:0] SEL_ORIGINY  = 4'd3;
  localparam logic [SEL_W-1:0] SEL_TEXTUREW = 4'd4;
  localparam logic [SEL_W-1:0] SEL_TEXTUREH = 4'd5;
  localparam logic [SEL_W-1:0] SEL_SCALEX   = 4'd6;
  localparam logic [SEL_W-1:0] SEL_SCALEY   = 4'd7;
  localparam logic [SEL_W-1:0] SEL_ANGLE    = 4'd8;

  localparam logic [PARAM_W-1:0] RST_ZERO    = 24'h000000;
  localparam logic [PARAM_W-1:0] RST_TEXTURE = 24'h004000;  // 64.0
  localparam logic [PARAM_W-1:0] RST_SCALE   = 24'h000100;  // 1.0

  // 360.0 degrees in 16.8, held in the 25-bit signed width of the wrap adder
  localparam logic signed [PARAM_W:0] ANGLE_WRAP_FX = 25'sd92160;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    COMMIT = 2'd2,
    ANIM   = 2'd3
  } seq_state_t;

  function automatic logic [PARAM_W-1:0] param_reset_value(input int unsigned idx);
    case (idx)
      4, 5:    return RST_TEXTURE;
      6, 7:    return RST_SCALE;
      default: return RST_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mode7_param_sequencer_if.sv
// Parameter write handshake between the user-input front end (master) and
// the parameter sequencer (slave).
//   wr_req  : request, held by the master until wr_ack
//   wr_sel  : slot index (0..8 valid)
//   wr_data : 16.8 value for the slot
//   wr_ack  : one-cycle acknowledge
//   wr_err  : one-cycle pulse with wr_ack for an out-of-range slot
interface mode7_param_sequencer_if;
  import mode7_pkg::*;

  logic               wr_req;
  logic [SEL_W-1:0]   wr_sel;
  logic [PARAM_W-1:0] wr_data;
  logic               wr_ack;
  logic               wr_err;

  modport master (output wr_req, output wr_sel, output wr_data,
                  input  wr_ack, input  wr_err);
  modport slave  (input  wr_req, input  wr_sel, input  wr_data,
                  output wr_ack, output wr_err);
endinterface

// File: rtl/mode7_angle_step.sv
// Combinational angle step with wrap into [0, 360) degrees.
//   angle     : current angle, 16.8, assumed in [0, 92160)
//   step      : signed 8.8 degrees, |step| < 128 degrees
//   angle_new : angle + step folded back into [0, 92160)
module mode7_angle_step
  import mode7_pkg::*;
(
  input  logic [PARAM_W-1:0] angle,
  input  logic signed [15:0] step,
  output logic [PARAM_W-1:0] angle_new
);

  // One correction is enough because the step magnitude is well under 360.
  function automatic logic [PARAM_W-1:0] wrap_angle(input logic signed [PARAM_W:0] sum);
    logic signed [PARAM_W:0] fixed;
    fixed = sum;
    if (sum[PARAM_W]) begin
      fixed = sum + ANGLE_WRAP_FX;
    end else if (sum >= ANGLE_WRAP_FX) begin
      fixed = sum - ANGLE_WRAP_FX;
    end
    return fixed[PARAM_W-1:0];
  endfunction

  logic signed [PARAM_W:0] angle_ext;
  logic signed [PARAM_W:0] step_ext;
  logic signed [PARAM_W:0] sum;

  // Both operands carry 8 fractional bits, so sign extension aligns them.
  assign angle_ext = $signed({1'b0, angle});
  assign step_ext  = $signed({{(PARAM_W+1-16){step[15]}}, step});
  assign sum       = angle_ext + step_ext;
  assign angle_new = wrap_angle(sum);

endmodule

// File: rtl/mode7_param_sequencer.sv
// Frame-synchronous parameter sequencer for the Mode 7 transform.
// Writes land in a shadow bank; the whole bank is copied to the active set at
// the start of vertical blanking so a frame never mixes parameter sets.
// Optionally steps the active angle once per frame.
//   clk, reset          : clock, asynchronous active-high reset
//   p_tick, pixel_y     : pixel enable and scan line from the VGA timing
//   wr                  : parameter write handshake (slave side)
//   anim_en, anim_step  : per-frame angle stepping control, step in 8.8 deg
//   offsetx..angle      : active parameter set, 16.8
//   commit              : one-cycle pulse when the active set changes
//   frame_count         : number of vblank commits since reset, wraps
module mode7_param_sequencer
  import mode7_pkg::*;
#(
  parameter int VBLANK_LINE = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p_tick,
  input  logic [9:0]               pixel_y,
  mode7_param_sequencer_if.slave   wr,
  input  logic                     anim_en,
  input  logic signed [15:0]       anim_step,
  output logic [PARAM_W-1:0]       offsetx,
  output logic [PARAM_W-1:0]       offsety,
  output logic [PARAM_W-1:0]       originx,
  output logic [PARAM_W-1:0]       originy,
  output logic [PARAM_W-1:0]       texturew,
  output logic [PARAM_W-1:0]       textureh,
  output logic [PARAM_W-1:0]       scalex,
  output logic [PARAM_W-1:0]       scaley,
  output logic [PARAM_W-1:0]       angle,
  output logic                     commit,
  output logic [15:0]              frame_count
);

  localparam logic [9:0] VB_LINE = 10'(VBLANK_LINE);

  seq_state_t         state_q, state_d;
  logic               vb, vb_q, vb_rise, frame_evt_q;
  logic               do_write, do_commit, do_anim, sel_bad;
  logic               wr_ack_q, wr_err_q, commit_q;
  logic [15:0]        frame_count_q;
  logic [PARAM_W-1:0] shadow_q [NUM_PARAMS];
  logic [PARAM_W-1:0] active_q [NUM_PARAMS];
  logic [PARAM_W-1:0] angle_next;

  // vb_q resets high so leaving reset inside vblank does not fake an entry.
  assign vb      = (pixel_y >= VB_LINE);
  assign vb_rise = p_tick & vb & ~vb_q;
  assign sel_bad = (wr.wr_sel >= SEL_W'(NUM_PARAMS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_q        <= 1'b1;
      frame_evt_q <= 1'b0;
    end else begin
      if (p_tick) begin
        vb_q <= vb;
      end
      frame_evt_q <= vb_rise | (frame_evt_q & ~do_commit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A pending frame event beats a pending write so the commit stays inside
  // vblank; the stalled write simply keeps wr_req high.
  always_comb begin
    state_d   = state_q;
    do_write  = 1'b0;
    do_commit = 1'b0;
    do_anim   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_evt_q) begin
          state_d = COMMIT;
        end else if (wr.wr_req) begin
          state_d  = WRITE;
          do_write = 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_d   = anim_en ? ANIM : IDLE;
      end
      ANIM: begin
        do_anim = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mode7_angle_step u_angle_step (
    .angle     (active_q[SEL_ANGLE]),
    .step      (anim_step),
    .angle_new (angle_next)
  );

  // Handshake and frame bookkeeping; the ack is raised on the same edge that
  // stores the data, so it is high for the one cycle spent in WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ack_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      commit_q      <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      wr_ack_q <= do_write;
      wr_err_q <= do_write & sel_bad;
      commit_q <= do_commit;
      if (do_commit) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  // Shadow and active banks. The animated angle is written to both banks so
  // the next commit carries it forward instead of reverting it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        shadow_q[i] <= param_reset_value(i);
        active_q[i] <= param_reset_value(i);
      end
    end else begin
      if (do_write && !sel_bad) begin
        for (int i = 0; i < NUM_PARAMS; i++) begin
          if (wr.wr_sel == SEL_W'(i)) begin
            shadow_q[i] <= wr.wr_data;
          end
        end
      end
      if (do_commit) begin
        for (int i = 0; i < NUM_PARAMS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (do_anim) begin
        active_q[SEL_ANGLE] <= angle_next;
        shadow_q[SEL_ANGLE] <= angle_next;
      end
    end
  end

  assign wr.wr_ack   = wr_ack_q;
  assign wr.wr_err   = wr_err_q;
  assign commit      = commit_q;
  assign frame_count = frame_count_q;
  assign offsetx     = active_q[SEL_OFFSETX];
  assign offsety     = active_q[SEL_OFFSETY];
  assign originx     = active_q[SEL_ORIGINX];
  assign originy     = active_q[SEL_ORIGINY];
  assign texturew    = active_q[SEL_TEXTUREW];
  assign textureh    = active_q[SEL_TEXTUREH];
  assign scalex      = active_q[SEL_SCALEX];
  assign scaley      = active_q[SEL_SCALEY];
  assign angle       = active_q[SEL_ANGLE];

endmodule

// File: tb/tb_mode7_param_sequencer.sv
// Scoreboard bench for mode7_param_sequencer: the driver updates a slot-level
// model of the shadow/active banks and queues the expected acknowledges and
// commits; a monitor on the falling edge pops and compares them.
module tb_mode7_param_sequencer;
  import mode7_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic [9:0]  pixel_y;
  logic        anim_en;
  logic [15:0] anim_step;
  logic [23:0] offsetx, offsety, originx, originy, texturew, textureh;
  logic [23:0] scalex, scaley, angle;
  logic        commit;
  logic [15:0] frame_count;

  mode7_param_sequencer_if wr_if ();

  mode7_param_sequencer #(.VBLANK_LINE(480)) dut (
    .clk         (clk),
    .reset       (reset),
    .p_tick      (p_tick),
    .pixel_y     (pixel_y),
    .wr          (wr_if),
    .anim_en     (anim_en),
    .anim_step   (anim_step),
    .offsetx     (offsetx),
    .offsety     (offsety),
    .originx     (originx),
    .originy     (originy),
    .texturew    (texturew),
    .textureh    (textureh),
    .scalex      (scalex),
    .scaley      (scaley),
    .angle       (angle),
    .commit      (commit),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [215:0] p;
    logic [15:0]  fc;
    logic         anim;
    logic [23:0]  anim_angle;
  } commit_exp_t;

  commit_exp_t cq[$];
  logic        aq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] m_shadow [9];
  logic [23:0] m_active [9];
  logic [15:0] m_fc;

  logic [215:0] dut_p;
  assign dut_p = {angle, scaley, scalex, textureh, texturew,
                  originy, originx, offsety, offsetx};

  task automatic check(input string name, input logic [215:0] act, input logic [215:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [215:0] pack_active();
    logic [215:0] p;
    for (int i = 0; i < 9; i++) p[i*24 +: 24] = m_active[i];
    return p;
  endfunction

  function automatic logic [215:0] default_params();
    logic [215:0] p;
    p = '0;
    p[4*24 +: 24] = 24'h004000;
    p[5*24 +: 24] = 24'h004000;
    p[6*24 +: 24] = 24'h000100;
    p[7*24 +: 24] = 24'h000100;
    return p;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) begin
      m_shadow[i] = 24'h0;
      m_active[i] = 24'h0;
    end
    m_shadow[4] = 24'h004000; m_active[4] = 24'h004000;
    m_shadow[5] = 24'h004000; m_active[5] = 24'h004000;
    m_shadow[6] = 24'h000100; m_active[6] = 24'h000100;
    m_shadow[7] = 24'h000100; m_active[7] = 24'h000100;
    m_fc = 16'd0;
  endfunction

  // Angle in degrees*256, wrapped into one turn.
  function automatic logic [23:0] model_wrap(input logic [23:0] a, input logic [15:0] s);
    int v;
    v = int'(a) + int'($signed(s));
    if (v >= 92160) v = v - 92160;
    else if (v < 0) v = v + 92160;
    return v[23:0];
  endfunction

  // Monitor
  logic        anim_due = 1'b0;
  logic [23:0] anim_exp = 24'h0;
  initial begin
    commit_exp_t c;
    logic        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        anim_due = 1'b0;
      end else begin
        if (anim_due) begin
          check("anim_angle", 216'(angle), 216'(anim_exp));
          anim_due = 1'b0;
        end
        if (wr_if.wr_err) check("err_needs_ack", 216'(wr_if.wr_ack), 216'(1));
        if (wr_if.wr_ack) begin
          check("ack_was_expected", 216'(aq.size() != 0), 216'(1));
          if (aq.size() != 0) begin
            e = aq.pop_front();
            check("wr_err", 216'(wr_if.wr_err), 216'(e));
          end
        end
        if (commit) begin
          check("commit_was_expected", 216'(cq.size() != 0), 216'(1));
          if (cq.size() != 0) begin
            c = cq.pop_front();
            check("commit_params", dut_p, c.p);
            check("frame_count", 216'(frame_count), 216'(c.fc));
            if (c.anim) begin
              anim_due = 1'b1;
              anim_exp = c.anim_angle;
            end
          end
        end
      end
    end
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic [9:0] y);
    pixel_y = y;
    p_tick  = 1'b1;
    step_cycle();
    p_tick  = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] sel, input logic [23:0] data);
    bit got;
    got = 1'b0;
    aq.push_back(sel >= 4'd9);
    wr_if.wr_req  = 1'b1;
    wr_if.wr_sel  = sel;
    wr_if.wr_data = data;
    for (int k = 0; k < 20; k++) begin
      step_cycle();
      if (wr_if.wr_ack) begin
        got = 1'b1;
        break;
      end
    end
    wr_if.wr_req = 1'b0;
    check("write_acked", 216'(got), 216'(1));
    if (got && sel < 4'd9) m_shadow[sel] = data;
  endtask

  // Enter vblank; with collide set, a write request is raised while the
  // frame event is already pending, so the commit goes first.
  task automatic vblank(input bit collide, input logic [3:0] sel, input logic [23:0] data);
    commit_exp_t c;
    for (int i = 0; i < 9; i++) m_active[i] = m_shadow[i];
    m_fc = m_fc + 16'd1;
    c.p    = pack_active();
    c.fc   = m_fc;
    c.anim = anim_en;
    c.anim_angle = 24'h0;
    if (anim_en) begin
      c.anim_angle = model_wrap(m_active[8], anim_step);
      m_active[8]  = c.anim_angle;
      m_shadow[8]  = c.anim_angle;
    end
    cq.push_back(c);
    pixel_y = 10'd480;
    repeat ($urandom_range(0, 2)) step_cycle();
    set_line(10'($urandom_range(480, 524)));
    if (collide) do_write(sel, data);
    repeat (6) step_cycle();
    set_line(10'($urandom_range(0, 479)));
  endtask

  initial begin
    logic [215:0] snap;
    logic [3:0]   sel;
    logic [23:0]  data;
    logic [15:0]  s;
    int           nw;

    reset = 1'b1;
    p_tick = 1'b0;
    pixel_y = 10'd0;
    anim_en = 1'b0;
    anim_step = 16'h0;
    wr_if.wr_req = 1'b0;
    wr_if.wr_sel = 4'd0;
    wr_if.wr_data = 24'h0;
    model_reset();
    repeat (3) step_cycle();
    check("rst_params", dut_p, default_params());
    check("rst_scalex", 216'(scalex), 216'(24'h000100));
    check("rst_texturew", 216'(texturew), 216'(24'h004000));
    check("rst_frame_count", 216'(frame_count), 216'(0));
    check("rst_ack_commit", 216'({wr_if.wr_ack, wr_if.wr_err, commit}), 216'(0));

    // Leaving reset inside vblank must not commit.
    pixel_y = 10'd490;
    reset = 1'b0;
    set_line(10'd490);
    repeat (3) step_cycle();
    set_line(10'd100);

    // Deferred write
    do_write(4'd0, 24'h001200);
    repeat (3) step_cycle();
    check("offsetx_deferred", 216'(offsetx), 216'(24'h000000));
    vblank(1'b0, 4'd0, 24'h0);
    check("offsetx_committed", 216'(offsetx), 216'(24'h001200));

    // Invalid slot
    snap = dut_p;
    do_write(4'd12, 24'hABCDEF);
    vblank(1'b0, 4'd0, 24'h0);
    check("invalid_no_change", dut_p, snap);

    // Positive and negative wrap
    anim_en = 1'b1;
    anim_step = 16'h0A00;
    do_write(4'd8, 24'h015E00);
    vblank(1'b0, 4'd0, 24'h0);
    check("angle_pos_wrap", 216'(angle), 216'(24'h000000));
    anim_step = 16'hFB00;
    do_write(4'd8, 24'h000200);
    vblank(1'b0, 4'd0, 24'h0);
    check("angle_neg_wrap", 216'(angle), 216'(24'h016500));
    anim_en = 1'b0;

    // Collision: write pending across the vblank entry
    vblank(1'b1, 4'd1, 24'h00ABCD);
    check("collision_deferred", 216'(offsety), 216'(m_active[1]));
    vblank(1'b0, 4'd0, 24'h0);
    check("collision_applied", 216'(offsety), 216'(24'h00ABCD));

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) begin
        sel  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        data = (sel == 4'd8) ? 24'($urandom_range(0, 92159)) : 24'($urandom);
        do_write(sel, data);
      end
      anim_en = 1'($urandom_range(0, 1));
      do s = 16'($urandom); while (s == 16'h8000);
      anim_step = s;
      check("held_params", dut_p, pack_active());
      sel  = 4'($urandom_range(0, 8));
      data = (sel == 4'd8) ? 24'($urandom_range(0, 92159)) : 24'($urandom);
      vblank($urandom_range(0, 3) == 0, sel, data);
    end

    // Reset mid-frame with a write in flight
    set_line(10'd200);
    do_write(4'd2, 24'h123456);
    wr_if.wr_req = 1'b1;
    wr_if.wr_sel = 4'd3;
    wr_if.wr_data = 24'h654321;
    step_cycle();
    #1;
    reset = 1'b1;
    wr_if.wr_req = 1'b0;
    aq.delete();
    cq.delete();
    model_reset();
    #1;
    check("midrst_params", dut_p, default_params());
    check("midrst_frame_count", 216'(frame_count), 216'(0));
    check("midrst_ack_commit", 216'({wr_if.wr_ack, wr_if.wr_err, commit}), 216'(0));
    step_cycle();
    step_cycle();
    reset = 1'b0;
    set_line(10'd200);
    do_write(4'd6, 24'h000280);
    vblank(1'b0, 4'd0, 24'h0);
    check("post_reset_scalex", 216'(scalex), 216'(24'h000280));

    repeat (10) step_cycle();
    check("commit_queue_drained", 216'(cq.size()), 216'(0));
    check("ack_queue_drained", 216'(aq.size()), 216'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
